// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// presents fetched instructions to the IF/ID register through a one-entry
// output buffer backed by a one-entry skid buffer.
//
// Ports
//   Clk, Clrn          clock (rising edge), asynchronous active-low reset
//   Stall              IF/ID register is not accepting this cycle
//   Pcsrc              next-PC select: 00 seq, 01 branch, 10 jump, 11 reg jump
//   Bpc, Jpc, Rpc      redirect targets for Pcsrc 01 / 10 / 11
//   Imem_req/_addr     read request and word address to instruction memory
//   Imem_ack/_rdata    read data valid (only meaningful with Imem_req) and data
//   IF_PC/_PC4/_Inst   fetched PC, PC+4 and instruction word
//   IF_Valid           IF_* hold a real fetched instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Stall,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Bpc,
  input  logic [31:0] Jpc,
  input  logic [31:0] Rpc,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_Inst,
  output logic        IF_Valid
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_pc4;
  logic [31:0] r_out_inst;
  logic        r_out_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_skid_valid;
  logic [31:0] r_drain_addr;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_out_pc_nxt;
  logic [31:0] w_out_pc4_nxt;
  logic [31:0] w_out_inst_nxt;
  logic        w_out_valid_nxt;
  logic [31:0] w_skid_pc_nxt;
  logic [31:0] w_skid_inst_nxt;
  logic        w_skid_valid_nxt;
  logic [31:0] w_drain_nxt;

  logic        w_req;
  logic        w_ack;
  logic        w_redirect;
  logic        w_consume;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  // Request is gated by the reset pin so it is low for the whole reset window,
  // even though the state register already reads RUN there.
  assign w_req      = (r_state != ST_HOLD);
  assign Imem_req   = Clrn & w_req;
  assign Imem_addr  = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign w_ack      = Imem_ack & Imem_req;
  assign w_redirect = (Pcsrc != 2'b00);
  assign w_consume  = r_out_valid & ~Stall;
  // Plain 32-bit add: wraps modulo 2^32 and leaves bits [1:0] untouched.
  assign w_pc_inc   = r_pc + 32'd4;

  assign IF_PC    = r_out_pc;
  assign IF_PC4   = r_out_pc4;
  assign IF_Inst  = r_out_inst;
  assign IF_Valid = r_out_valid;

  // Redirect target selection.
  always_comb begin
    w_target = r_pc;
    case (Pcsrc)
      2'b01:   w_target = Bpc;
      2'b10:   w_target = Jpc;
      2'b11:   w_target = Rpc;
      default: w_target = r_pc;
    endcase
  end

  // Next-state and datapath update; a redirect overrides stall, ack and state.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_out_pc_nxt     = r_out_pc;
    w_out_pc4_nxt    = r_out_pc4;
    w_out_inst_nxt   = r_out_inst;
    w_out_valid_nxt  = r_out_valid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_inst_nxt  = r_skid_inst;
    w_skid_valid_nxt = r_skid_valid;
    w_drain_nxt      = r_drain_addr;

    if (w_redirect) begin
      w_pc_nxt         = w_target;
      w_out_pc_nxt     = 32'h0000_0000;
      w_out_pc4_nxt    = 32'h0000_0000;
      w_out_inst_nxt   = 32'h0000_0000;
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
      case (r_state)
        ST_RUN: begin
          // An outstanding request must still be answered by memory; keep
          // its address on the bus in DRAIN so the target fetch is not
          // confused with the stale response.
          if (!w_ack) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = r_pc;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: w_state_nxt = ST_DRAIN;
        default:  w_state_nxt = ST_RUN;
      endcase
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_ack) begin
            w_pc_nxt = w_pc_inc;
            if (!r_out_valid || w_consume) begin
              w_out_pc_nxt    = r_pc;
              w_out_pc4_nxt   = w_pc_inc;
              w_out_inst_nxt  = Imem_rdata;
              w_out_valid_nxt = 1'b1;
            end else begin
              // Output full and stalled: park the word and stop requesting.
              w_skid_pc_nxt    = r_pc;
              w_skid_inst_nxt  = Imem_rdata;
              w_skid_valid_nxt = 1'b1;
              w_state_nxt      = ST_HOLD;
            end
          end else if (w_consume) begin
            w_out_pc_nxt    = 32'h0000_0000;
            w_out_pc4_nxt   = 32'h0000_0000;
            w_out_inst_nxt  = 32'h0000_0000;
            w_out_valid_nxt = 1'b0;
          end else begin
            w_out_valid_nxt = r_out_valid;
          end
        end
        ST_HOLD: begin
          if (!Stall) begin
            w_out_pc_nxt     = r_skid_pc;
            w_out_pc4_nxt    = r_skid_pc + 32'd4;
            w_out_inst_nxt   = r_skid_inst;
            w_out_valid_nxt  = r_skid_valid;
            w_skid_valid_nxt = 1'b0;
            w_state_nxt      = ST_RUN;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          // Response to the pre-redirect address is dropped.
          if (w_ack) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_out_pc     <= 32'h0000_0000;
      r_out_pc4    <= 32'h0000_0000;
      r_out_inst   <= 32'h0000_0000;
      r_out_valid  <= 1'b0;
      r_skid_pc    <= 32'h0000_0000;
      r_skid_inst  <= 32'h0000_0000;
      r_skid_valid <= 1'b0;
      r_drain_addr <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_out_pc4    <= w_out_pc4_nxt;
      r_out_inst   <= w_out_inst_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_inst  <= w_skid_inst_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_drain_addr <= w_drain_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scenarios for if_fetch_unit with a wait-state memory model.
// Stimulus pushes the PCs expected to be consumed into a queue; a monitor
// pops and compares on every consumption (IF_Valid=1, Stall=0) and checks
// that Imem_addr is stable while a request is outstanding.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        Clk;
  logic        Clrn;
  logic        Stall;
  logic [1:0]  Pcsrc;
  logic [31:0] Bpc, Jpc, Rpc;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;
  logic [31:0] IF_PC, IF_PC4, IF_Inst;
  logic        IF_Valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // memory model controls
  logic        mem_en;
  int          mem_wait;
  int          wcnt;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Clrn(Clrn), .Stall(Stall), .Pcsrc(Pcsrc),
    .Bpc(Bpc), .Jpc(Jpc), .Rpc(Rpc),
    .Imem_req(Imem_req), .Imem_addr(Imem_addr),
    .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
    .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst), .IF_Valid(IF_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory: acknowledges after mem_wait full cycles of an outstanding request.
  assign Imem_ack   = mem_en && Imem_req && (wcnt >= mem_wait);
  assign Imem_rdata = Imem_ack ? mem_word(Imem_addr) : 32'h0000_0000;

  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn) wcnt <= 0;
    else if (Imem_req && !Imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge sees.
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr    = 32'h0;
  logic [31:0] mon_e;
  always @(negedge Clk) begin
    if (Clrn) begin
      if (prev_pending && Imem_req) chk("addr_stable", Imem_addr, prev_addr);
      prev_pending = Imem_req && !Imem_ack;
      prev_addr    = Imem_addr;
      if (IF_Valid && !Stall) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got pc %h expected none at %0t", IF_PC, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pc", IF_PC, mon_e);
          chk("sb_pc4", IF_PC4, mon_e + 32'd4);
          chk("sb_inst", IF_Inst, mem_word(mon_e));
        end
      end
    end else begin
      prev_pending = 1'b0;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Assert reset, check outputs clear at once, release, check first request.
  task automatic do_reset();
    Clrn = 1'b0;
    #1;
    chk("rst_req", {31'h0, Imem_req}, 32'h0);
    chk("rst_valid", {31'h0, IF_Valid}, 32'h0);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_pc4", IF_PC4, 32'h0);
    chk("rst_inst", IF_Inst, 32'h0);
    step();
    step();
    Clrn = 1'b1;
    #1;
    chk("rel_req", {31'h0, Imem_req}, 32'h1);
    chk("rel_addr", Imem_addr, 32'h0000_0000);
  endtask

  task automatic finish_scn(input string name);
    step();
    step();
    chk(name, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    Clrn = 1'b0; Stall = 1'b0; Pcsrc = 2'b00;
    Bpc = 32'h0; Jpc = 32'h0; Rpc = 32'h0;
    mem_en = 1'b0; mem_wait = 0;
    step();
    step();

    // 1: zero-wait streaming, four instructions
    mem_wait = 0; mem_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s1_valid", {31'h0, IF_Valid}, 32'h1);
      chk("s1_pc", IF_PC, 32'(4 * (k - 1)));
      if (k == 4) mem_en = 1'b0;
    end
    step();
    chk("s1_bubble", {31'h0, IF_Valid}, 32'h0);
    finish_scn("s1_sb_empty");

    // 2: two wait states -> one valid cycle in three, bubbles are zero
    mem_wait = 2; mem_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) mem_en = 1'b0;
      chk("s2_valid", {31'h0, IF_Valid}, (k == 3 || k == 6 || k == 9) ? 32'h1 : 32'h0);
      if (!(k == 3 || k == 6 || k == 9)) chk("s2_gap_inst", IF_Inst, 32'h0);
    end
    finish_scn("s2_sb_empty");

    // 3: stall three cycles at PC=8, next fetch goes to the skid buffer
    mem_wait = 0; mem_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    do_reset();
    step(); step(); step();
    chk("s3_pc8", IF_PC, 32'h8);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s3_hold_pc", IF_PC, 32'h8);
      chk("s3_hold_req", {31'h0, Imem_req}, 32'h0);
    end
    Stall = 1'b0;
    step();
    chk("s3_pcC", IF_PC, 32'hC);
    chk("s3_req_back", {31'h0, Imem_req}, 32'h1);
    step();
    chk("s3_pc10", IF_PC, 32'h10);
    mem_en = 1'b0;
    step();
    chk("s3_bubble", {31'h0, IF_Valid}, 32'h0);
    finish_scn("s3_sb_empty");

    // 4: branch while fetch of 0x10 is waiting -> drain then target 0x40
    mem_wait = 0; mem_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h40);
    do_reset();
    step(); step(); step(); step();
    mem_en = 1'b0;
    step();
    chk("s4_wait_addr", Imem_addr, 32'h10);
    Pcsrc = 2'b01; Bpc = 32'h40;
    step();
    Pcsrc = 2'b00;
    chk("s4_drain_addr", Imem_addr, 32'h10);
    chk("s4_drain_req", {31'h0, Imem_req}, 32'h1);
    chk("s4_drain_valid", {31'h0, IF_Valid}, 32'h0);
    mem_en = 1'b1;
    step();
    chk("s4_dropped", {31'h0, IF_Valid}, 32'h0);
    chk("s4_target_addr", Imem_addr, 32'h40);
    step();
    chk("s4_pc40", IF_PC, 32'h40);
    mem_en = 1'b0;
    finish_scn("s4_sb_empty");

    // 5: jump in the same cycle as an ack
    mem_wait = 0; mem_en = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h100);
    do_reset();
    step();
    chk("s5_pc0", IF_PC, 32'h0);
    Pcsrc = 2'b10; Jpc = 32'h100;
    step();
    Pcsrc = 2'b00;
    chk("s5_valid0", {31'h0, IF_Valid}, 32'h0);
    chk("s5_addr", Imem_addr, 32'h100);
    step();
    chk("s5_pc100", IF_PC, 32'h100);
    mem_en = 1'b0;
    finish_scn("s5_sb_empty");

    // 6: reset pulse during a pending fetch at 0x20
    mem_wait = 0; mem_en = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(4 * k));
    do_reset();
    for (int k = 0; k < 8; k++) step();
    mem_en = 1'b0;
    chk("s6_valid_pre", {31'h0, IF_Valid}, 32'h1);
    chk("s6_pc_pre", IF_PC, 32'h1C);
    chk("s6_addr_pre", Imem_addr, 32'h20);
    mem_en = 1'b1;
    exp_q.push_back(32'h0);
    do_reset();
    step();
    chk("s6_first_pc", IF_PC, 32'h0);
    mem_en = 1'b0;
    finish_scn("s6_sb_empty");

    // 7: register jump near the top of memory; wrap and low bits preserved
    mem_wait = 0; mem_en = 1'b1;
    Pcsrc = 2'b11; Rpc = 32'hFFFF_FFFE;
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'h0000_0002);
    do_reset();
    step();
    Pcsrc = 2'b00;
    chk("s7_valid0", {31'h0, IF_Valid}, 32'h0);
    chk("s7_addr", Imem_addr, 32'hFFFF_FFFE);
    step();
    chk("s7_pc", IF_PC, 32'hFFFF_FFFE);
    chk("s7_pc4", IF_PC4, 32'h0000_0002);
    chk("s7_wrap_addr", Imem_addr, 32'h0000_0002);
    step();
    chk("s7_pc2", IF_PC, 32'h0000_0002);
    mem_en = 1'b0;
    finish_scn("s7_sb_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 Clrn  input  1  reset, asynchronous, active-low.
REQ-004 Stall  input  1  downstream hold; 1 = the IF/ID register is not accepting.
REQ-005 Pcsrc  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 register jump.
REQ-006 Bpc / Jpc / Rpc  input  32 each  redirect targets for Pcsrc 01 / 10 / 11.
REQ-007 Imem_req  output  1  instruction memory read request.
REQ-008 Imem_addr  output  32  instruction memory word address.
REQ-009 Imem_ack  input  1  read data valid; meaningful only while Imem_req=1.
REQ-010 Imem_rdata  input  32  instruction word, valid when Imem_ack=1.
REQ-011 IF_PC / IF_PC4 / IF_Inst  output  32 each  fetched PC, PC+4 and instruction for the IF/ID register.
REQ-012 IF_Valid  output  1  IF_PC/IF_PC4/IF_Inst hold a real fetched instruction.

Function
REQ-013 The block SHALL hold PC, a one-entry output buffer (IF_*), a one-entry skid buffer, a drain address and a state register with states RUN, HOLD and DRAIN.
REQ-014 Consumption SHALL occur on any rising edge where IF_Valid=1 and Stall=0.
REQ-015 In RUN, Imem_req SHALL be 1 and Imem_addr SHALL equal PC.
REQ-016 Once Imem_req rises, Imem_addr SHALL stay stable until Imem_ack; same-cycle ack (zero wait) SHALL be supported.
REQ-017 RUN with ack and no redirect: if the buffer is empty or being consumed, load IF_Inst=Imem_rdata, IF_PC=PC, IF_PC4=PC+4 and IF_Valid=1, then set PC=PC+4.
REQ-018 RUN with ack while the buffer is full and Stall=1: write data/PC into the skid buffer, set PC=PC+4 and go to HOLD.
REQ-019 RUN with no ack: if the buffer is consumed, IF_Valid SHALL drop to 0 and IF_PC, IF_PC4 and IF_Inst SHALL clear to 0 (bubble nop).
REQ-020 In HOLD, Imem_req SHALL be 0; on the first edge with Stall=0, move the skid entry into the output buffer and return to RUN.
REQ-021 Redirect occurs when Pcsrc!=00 on an edge and SHALL take priority over Stall, ack and state.
REQ-022 On redirect, the block SHALL set PC to the selected target, clear IF_Valid and all IF_* to 0, and discard the skid buffer.
REQ-023 On redirect, the next state SHALL be DRAIN if in RUN with the request unacknowledged that cycle; otherwise RUN. Redirect in DRAIN SHALL stay in DRAIN.
REQ-024 In DRAIN, Imem_req SHALL be 1 with Imem_addr equal to the latched pre-redirect address; the ack data SHALL be discarded, then the block returns to RUN.
REQ-025 Redirect and ack in the same RUN cycle SHALL discard the data and issue the target fetch on the next cycle.
REQ-026 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 0); bits [1:0] SHALL pass through unchanged.
REQ-027 Fetch-to-IF_Valid latency SHALL be one edge: an ack sampled at edge N makes the output visible after edge N.

Reset
REQ-028 While Clrn=0: PC=RESET_PC, state=RUN, IF_Valid=0, IF_PC/IF_PC4/IF_Inst=0, skid buffer empty, drain address=0.
REQ-029 While Clrn=0, Imem_req SHALL be 0.
REQ-030 Reset asserted mid-request SHALL abandon the request without drain; the first request after release SHALL address RESET_PC.

Verification
REQ-031 Zero-wait memory, Stall=0, 4 cycles -> IF_PC=0,4,8,C on consecutive cycles; IF_PC4=PC+4; IF_Valid held 1.
REQ-032 Memory with 2 wait states -> IF_Valid pulses 1 for one cycle in every 3 with IF_Inst=0 in the gaps; Imem_addr stable during each wait.
REQ-033 Stall=1 for 3 cycles with zero-wait memory at PC=8 -> IF_PC stays 8, the PC=C fetch goes to skid, Imem_req=0 in HOLD; after Stall=0, IF_PC=C then 10 with no lost or duplicated instruction.
REQ-034 Pcsrc=01, Bpc=40 while a fetch of 10 is waiting -> DRAIN re-presents address 10, its data is dropped, the next request is 40, and IF_PC=40 is the next valid output.
REQ-035 Pcsrc=10 with Jpc=100, same cycle as ack -> the acked data is dropped, Imem_addr=100 next cycle, and IF_Valid=0 for that cycle.
REQ-036 Clrn pulsed low during a pending fetch at PC=20 -> outputs clear immediately, and after release Imem_addr=RESET_PC with no drain cycle.
